// File: rtl/alu_issue_queue_if.sv
// Bundle of dispatch, CDB wakeup and issue signals around the ALU issue queue.
// The master side is rename/dispatch plus the CDB; the slave side is the queue itself.
interface alu_issue_queue_if #(
  parameter int DEPTH  = 8,
  parameter int XLEN   = 32,
  parameter int PTAG_W = 6
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              disp_valid_i;
  logic              disp_ready_o;
  logic [2:0]        disp_alu_op_i;
  logic              disp_src1_rdy_i;
  logic [PTAG_W-1:0] disp_src1_tag_i;
  logic [XLEN-1:0]   disp_src1_val_i;
  logic              disp_src2_rdy_i;
  logic [PTAG_W-1:0] disp_src2_tag_i;
  logic [XLEN-1:0]   disp_src2_val_i;
  logic [PTAG_W-1:0] disp_rd_p_i;
  logic [PTAG_W-1:0] disp_rob_tag_i;
  logic              cdb_valid_i;
  logic [PTAG_W-1:0] cdb_tag_i;
  logic [XLEN-1:0]   cdb_data_i;
  logic              issue_valid_o;
  logic [2:0]        issue_alu_op_o;
  logic [XLEN-1:0]   issue_op1_o;
  logic [XLEN-1:0]   issue_op2_o;
  logic [PTAG_W-1:0] issue_rd_p_o;
  logic [PTAG_W-1:0] issue_rob_tag_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output flush_i, disp_valid_i, disp_alu_op_i,
           disp_src1_rdy_i, disp_src1_tag_i, disp_src1_val_i,
           disp_src2_rdy_i, disp_src2_tag_i, disp_src2_val_i,
           disp_rd_p_i, disp_rob_tag_i, cdb_valid_i, cdb_tag_i, cdb_data_i,
    input  disp_ready_o, issue_valid_o, issue_alu_op_o, issue_op1_o, issue_op2_o,
           issue_rd_p_o, issue_rob_tag_o, count_o
  );

  modport slave (
    input  flush_i, disp_valid_i, disp_alu_op_i,
           disp_src1_rdy_i, disp_src1_tag_i, disp_src1_val_i,
           disp_src2_rdy_i, disp_src2_tag_i, disp_src2_val_i,
           disp_rd_p_i, disp_rob_tag_i, cdb_valid_i, cdb_tag_i, cdb_data_i,
    output disp_ready_o, issue_valid_o, issue_alu_op_o, issue_op1_o, issue_op2_o,
           issue_rd_p_o, issue_rob_tag_o, count_o
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Reservation station for the single-cycle ALU: captures operands from the CDB and
// issues the oldest fully-ready micro-op each cycle through registered outputs.
module alu_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int XLEN   = 32,
  parameter int PTAG_W = 6
) (
  input logic             clk,
  input logic             rst,
  alu_issue_queue_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // age_r[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  s1_rdy_r;
  logic [DEPTH-1:0]  s2_rdy_r;
  logic [DEPTH-1:0]  age_r    [DEPTH];
  logic [2:0]        op_r     [DEPTH];
  logic [PTAG_W-1:0] s1_tag_r [DEPTH];
  logic [PTAG_W-1:0] s2_tag_r [DEPTH];
  logic [XLEN-1:0]   s1_val_r [DEPTH];
  logic [XLEN-1:0]   s2_val_r [DEPTH];
  logic [PTAG_W-1:0] rd_r     [DEPTH];
  logic [PTAG_W-1:0] rob_r    [DEPTH];
  logic [CNT_W-1:0]  count_r;

  logic              issue_valid_r;
  logic [2:0]        issue_op_r;
  logic [XLEN-1:0]   issue_op1_r;
  logic [XLEN-1:0]   issue_op2_r;
  logic [PTAG_W-1:0] issue_rd_r;
  logic [PTAG_W-1:0] issue_rob_r;

  logic              disp_ready_s;
  logic              disp_fire_s;
  logic [IDX_W-1:0]  free_idx_s;
  logic [DEPTH-1:0]  rdy_s;
  logic [DEPTH-1:0]  older_rdy_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic              sel_valid_s;
  logic              d1_rdy_s;
  logic              d2_rdy_s;
  logic [XLEN-1:0]   d1_val_s;
  logic [XLEN-1:0]   d2_val_s;

  assign disp_ready_s = (count_r < CNT_W'(DEPTH));
  assign disp_fire_s  = bus.disp_valid_i & disp_ready_s & ~bus.flush_i;

  // Lowest-numbered free slot receives the next dispatch
  always_comb begin
    free_idx_s = {IDX_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_idx_s = valid_r[i] ? free_idx_s : IDX_W'(i);
    end
  end

  // Oldest ready entry: the one no other ready entry is older than
  always_comb begin
    rdy_s       = valid_r & s1_rdy_r & s2_rdy_r;
    older_rdy_s = {DEPTH{1'b0}};
    sel_idx_s   = {IDX_W{1'b0}};
    sel_valid_s = |rdy_s;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older_rdy_s[i] = older_rdy_s[i] | (rdy_s[j] & age_r[j][i]);
      end
      if (rdy_s[i] && !older_rdy_s[i]) begin
        sel_idx_s = IDX_W'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
  end

  // Dispatch-time bypass of an operand being broadcast in the same cycle
  always_comb begin
    d1_rdy_s = bus.disp_src1_rdy_i |
               (bus.cdb_valid_i & (bus.cdb_tag_i == bus.disp_src1_tag_i));
    d2_rdy_s = bus.disp_src2_rdy_i |
               (bus.cdb_valid_i & (bus.cdb_tag_i == bus.disp_src2_tag_i));
    d1_val_s = bus.disp_src1_rdy_i ? bus.disp_src1_val_i : bus.cdb_data_i;
    d2_val_s = bus.disp_src2_rdy_i ? bus.disp_src2_val_i : bus.cdb_data_i;
  end

  // Entry state: wakeup, free on select, allocate on dispatch, age tracking
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      valid_r  <= {DEPTH{1'b0}};
      s1_rdy_r <= {DEPTH{1'b0}};
      s2_rdy_r <= {DEPTH{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        age_r[i] <= {DEPTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_r[i] && bus.cdb_valid_i) begin
          if (!s1_rdy_r[i] && (s1_tag_r[i] == bus.cdb_tag_i)) begin
            s1_rdy_r[i] <= 1'b1;
            s1_val_r[i] <= bus.cdb_data_i;
          end
          if (!s2_rdy_r[i] && (s2_tag_r[i] == bus.cdb_tag_i)) begin
            s2_rdy_r[i] <= 1'b1;
            s2_val_r[i] <= bus.cdb_data_i;
          end
        end
      end
      if (sel_valid_s) begin
        valid_r[sel_idx_s] <= 1'b0;
      end
      // The free slot never equals the selected one, so both updates can coexist
      if (disp_fire_s) begin
        valid_r[free_idx_s]  <= 1'b1;
        op_r[free_idx_s]     <= bus.disp_alu_op_i;
        s1_rdy_r[free_idx_s] <= d1_rdy_s;
        s1_tag_r[free_idx_s] <= bus.disp_src1_tag_i;
        s1_val_r[free_idx_s] <= d1_val_s;
        s2_rdy_r[free_idx_s] <= d2_rdy_s;
        s2_tag_r[free_idx_s] <= bus.disp_src2_tag_i;
        s2_val_r[free_idx_s] <= d2_val_s;
        rd_r[free_idx_s]     <= bus.disp_rd_p_i;
        rob_r[free_idx_s]    <= bus.disp_rob_tag_i;
        for (int j = 0; j < DEPTH; j++) begin
          age_r[free_idx_s][j] <= 1'b0;
          age_r[j][free_idx_s] <= valid_r[j] && (IDX_W'(j) != free_idx_s);
        end
      end
      count_r <= count_r + CNT_W'(disp_fire_s) - CNT_W'(sel_valid_s);
    end
  end

  // Registered issue port; data holds when nothing is selected
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_r <= 1'b0;
      issue_op_r    <= 3'b000;
      issue_op1_r   <= {XLEN{1'b0}};
      issue_op2_r   <= {XLEN{1'b0}};
      issue_rd_r    <= {PTAG_W{1'b0}};
      issue_rob_r   <= {PTAG_W{1'b0}};
    end else if (bus.flush_i) begin
      issue_valid_r <= 1'b0;
    end else begin
      issue_valid_r <= sel_valid_s;
      if (sel_valid_s) begin
        issue_op_r  <= op_r[sel_idx_s];
        issue_op1_r <= s1_val_r[sel_idx_s];
        issue_op2_r <= s2_val_r[sel_idx_s];
        issue_rd_r  <= rd_r[sel_idx_s];
        issue_rob_r <= rob_r[sel_idx_s];
      end
    end
  end

  assign bus.disp_ready_o    = disp_ready_s;
  assign bus.count_o         = count_r;
  assign bus.issue_valid_o   = issue_valid_r;
  assign bus.issue_alu_op_o  = issue_op_r;
  assign bus.issue_op1_o     = issue_op1_r;
  assign bus.issue_op2_o     = issue_op2_r;
  assign bus.issue_rd_p_o    = issue_rd_r;
  assign bus.issue_rob_tag_o = issue_rob_r;
endmodule
